positdiv_seq: RTL and testbench
===============================

POSITDIV_SEQ -- requirements
Module: positdiv_seq

Interface
REQ-001 SHALL have parameters: NBITS, default 32, posit width; ES, default 2, exponent bits; QBITS, default 30, quotient bits produced.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port in1  input  NBITS  dividend posit.
REQ-006 SHALL have port in2  input  NBITS  divisor posit.
REQ-007 SHALL have port result  output  NBITS  quotient posit, registered.
REQ-008 SHALL have port inf  output  1  result is NaR (0x80000000).
REQ-009 SHALL have port zero  output  1  result is zero.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result/inf/zero valid.
REQ-011 SHALL have port busy  output  1  high from the cycle after start acceptance until done.

Function
REQ-012 SHALL implement states IDLE, DIVIDE, ENCODE, DONE; IDLE->DIVIDE on start; DIVIDE->ENCODE after QBITS iterations; ENCODE->DONE; DONE->IDLE unconditionally.
REQ-013 SHALL register in1/in2 on the accepting edge; later input changes SHALL NOT affect the operation.
REQ-014 SHALL assert done exactly QBITS+2 cycles after the accepting edge (32 for defaults), for one cycle, regardless of operand values or special cases.
REQ-015 SHALL ignore start while busy or in DONE; no queueing.
REQ-016 SHALL hold result/inf/zero stable from done until the next done.
REQ-017 SHALL decode each operand to sign, scale (regime*2^ES + exponent), and fraction with hidden bit restored (NBITS-4 bits incl. hidden).
REQ-018 SHALL compute the quotient by restoring division: one bit per DIVIDE cycle, MSB first, quotient bit 1 = integer bit.
REQ-019 SHALL, if the quotient integer bit is 0, shift the quotient left 1 and decrement scale by 1.
REQ-020 SHALL compute scale = scale1 - scale2 (- normalize) in a signed width of at least 10 bits.
REQ-021 SHALL set sticky = (nonzero final remainder) OR any quotient bit below the guard position.
REQ-022 SHALL round to nearest, ties to even, using guard and sticky on the unsigned regime|exponent|fraction.
REQ-023 SHALL saturate: scale > (NBITS-2)*2^ES gives maxpos (0x7FFFFFFF); scale < -(NBITS-2)*2^ES gives minpos (0x00000001); a nonzero quotient never rounds to zero or NaR.
REQ-024 SHALL make the sign = sign1 XOR sign2, and produce a negative result by two's complement of the NBITS-1 magnitude bits.
REQ-025 SHALL set the special cases:
- in1 or in2 = NaR, or in2 = 0: result 0x80000000, inf=1, zero=0.
- otherwise, in1 = 0: result 0, zero=1, inf=0.
REQ-026 SHALL keep inf and zero mutually exclusive.

Reset
REQ-027 SHALL, on reset_n low, immediately force state IDLE and result=0, inf=0, zero=0, done=0, busy=0, and clear the quotient/remainder/counter registers.
REQ-028 SHALL abandon an in-flight operation when reset is asserted mid-operation; no done pulse SHALL follow the release of reset.
REQ-029 SHALL accept start on the first rising edge after reset_n deasserts.

Structure
REQ-030 SHALL take NBITS, ES, and the decoded-value struct (sign, scale, fraction, zero, inf) from the shared posit_defines package; QBITS and the state enum are local.
REQ-031 SHALL instantiate the existing posit_extract twice for operand decode; the divider iteration and encode stay in this module; no new sub-module.

Verification
REQ-032 SHALL cover: in1=0x40000000 (1.0), in2=0x40000000 -> result 0x40000000, done at +32 cycles.
REQ-033 SHALL cover: in1=0x40000000, in2=0x48000000 (2.0) -> 0x38000000; in1=0x40000000, in2=0x4C000000 (3.0) -> 0x32AAAAAB (round up via sticky).
REQ-034 SHALL cover: in1=0xC0000000 (-1.0), in2=0x48000000 -> 0xC8000000 (-0.5).
REQ-035 SHALL cover special cases: in2=0 -> 0x80000000, inf=1; in1=0, in2=0x40000000 -> 0, zero=1; in1=0x7FFFFFFF, in2=0x00000001 -> 0x7FFFFFFF; in1=0x00000001, in2=0x7FFFFFFF -> 0x00000001.
REQ-036 SHALL cover: start re-pulsed at +5 cycles with different operands -> ignored, first result unchanged.
REQ-037 SHALL cover: reset_n low at +10 cycles -> outputs 0 at once, no done; a new start then completes normally.

Source files
------------

// File: rtl/posit_defines.sv
// Shared posit format constants and the decoded-operand record.
package posit_defines;

    localparam int NBITS   = 32;
    localparam int ES      = 2;
    localparam int SCALE_W = 10;
    localparam int FRAC_W  = NBITS - 4;

    typedef struct packed {
        logic               sign;
        logic [SCALE_W-1:0] scale;
        logic [FRAC_W-1:0]  fraction;
        logic               zero;
        logic               inf;
    } posit_t;

endpackage

// File: rtl/posit_extract.sv
// Combinational posit decode: sign, scale = regime*2^ES + exponent, fraction with hidden bit.
module posit_extract
    import posit_defines::*;
(
    input  logic [NBITS-1:0] posit,
    output posit_t           value
);

    localparam int RW = $clog2(NBITS) + 1;

    logic [NBITS-2:0]        body;
    logic [NBITS-4:0]        tail;
    logic [ES+FRAC_W-2:0]    rest;
    logic [RW-1:0]           run;
    logic [SCALE_W-1:0]      k;
    logic                    rc;
    logic                    stop;
    logic                    is_zero;
    logic                    is_nar;

    always_comb begin
        body    = posit[NBITS-1] ? -posit[NBITS-2:0] : posit[NBITS-2:0];
        rc      = body[NBITS-2];
        run     = '0;
        stop    = 1'b0;
        for (int unsigned i = 0; i < NBITS - 1; i++) begin
            if (!stop) begin
                if (body[NBITS-2-i] == rc) run = run + 1'b1;
                else                       stop = 1'b1;
            end
        end
        k = rc ? SCALE_W'(run) - SCALE_W'(1) : -SCALE_W'(run);

        // The regime is at least two bits, so the top two body bits never reach the tail.
        tail = body[NBITS-4:0];
        rest = tail << (run - 1'b1);

        is_zero = (posit == '0);
        is_nar  = (posit == {1'b1, {(NBITS-1){1'b0}}});

        value.sign     = posit[NBITS-1];
        value.zero     = is_zero;
        value.inf      = is_nar;
        value.scale    = (k << ES) | {{(SCALE_W-ES){1'b0}}, rest[ES+FRAC_W-2 -: ES]};
        value.fraction = {1'b1, rest[FRAC_W-2:0]};
        if (is_zero || is_nar) begin
            value.scale    = '0;
            value.fraction = '0;
        end
    end

endmodule

// File: rtl/positdiv_seq.sv
// Sequential posit divider: restoring division one quotient bit per cycle, then
// normalize, round-to-nearest-even and encode. done fires QBITS+2 cycles after start.
module positdiv_seq #(
    parameter int NBITS = posit_defines::NBITS,
    parameter int ES    = posit_defines::ES,
    parameter int QBITS = 30
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [NBITS-1:0] in1,
    input  logic [NBITS-1:0] in2,
    output logic [NBITS-1:0] result,
    output logic             inf,
    output logic             zero,
    output logic             done,
    output logic             busy
);

    localparam int SW = posit_defines::SCALE_W;
    localparam int FW = posit_defines::FRAC_W;
    localparam int CW = $clog2(QBITS);
    localparam int XW = 2 + ES + (QBITS - 1) + (NBITS - 1);
    localparam logic signed [SW-1:0] SCALE_MAX = SW'((NBITS - 2) * (2 ** ES));
    localparam logic signed [SW-1:0] SCALE_MIN = -SCALE_MAX;

    typedef enum logic [1:0] {IDLE, DIVIDE, ENCODE, DONE} state_t;

    state_t state, state_next;

    logic [NBITS-1:0]       op1, op2;
    logic [CW-1:0]          cnt;
    logic [QBITS-1:0]       quo;
    logic [FW:0]            rem;
    logic [QBITS-2:0]       n_frac;
    logic signed [SW-1:0]   n_scale;
    logic                   n_sticky, n_sign, n_inf, n_zero;

    posit_defines::posit_t  dec1, dec2;

    logic [FW:0]            rem_cur, rem_sub, rem_next;
    logic                   ge;
    logic [QBITS-1:0]       q_next;
    logic                   int_bit;
    logic [QBITS-2:0]       norm_frac;
    logic signed [SW-1:0]   norm_scale;
    logic [SW-1:0]          k, sh;
    logic [XW-1:0]          x, y;
    logic [NBITS-2:0]       mag_t, mag;
    logic                   guard, sticky_all, round_up;
    logic [NBITS-1:0]       enc_result;

    posit_extract u_ext1 (.posit(op1), .value(dec1));
    posit_extract u_ext2 (.posit(op2), .value(dec2));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        case (state)
            IDLE:    if (start) state_next = DIVIDE;
            DIVIDE:  if (cnt == CW'(QBITS - 1)) state_next = ENCODE;
            ENCODE:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        busy = (state != IDLE);
    end

    // The first iteration takes the dividend fraction straight from the decoder.
    always_comb begin
        rem_cur    = (cnt == '0) ? {1'b0, dec1.fraction} : rem;
        ge         = (rem_cur >= {1'b0, dec2.fraction});
        rem_sub    = ge ? rem_cur - {1'b0, dec2.fraction} : rem_cur;
        rem_next   = rem_sub << 1;
        q_next     = {quo[QBITS-2:0], ge};

        int_bit    = quo[QBITS-1];
        norm_frac  = int_bit ? quo[QBITS-2:0] : {quo[QBITS-3:0], 1'b0};
        norm_scale = dec1.scale - dec2.scale - {{(SW-1){1'b0}}, ~int_bit};
    end

    // Regime pattern '10' (k>=0) or '01' (k<0) is arithmetically shifted to build the run.
    always_comb begin
        k          = n_scale >>> ES;
        sh         = k[SW-1] ? ~k : k;
        x          = {(k[SW-1] ? 2'b01 : 2'b10), n_scale[ES-1:0], n_frac, {(NBITS-1){1'b0}}};
        y          = $signed(x) >>> sh;
        mag_t      = y[XW-1 -: NBITS-1];
        guard      = y[XW-NBITS];
        sticky_all = (|y[XW-NBITS-1:0]) | n_sticky;
        round_up   = guard & (sticky_all | mag_t[0]);
        mag        = (round_up && mag_t != '1) ? mag_t + 1'b1 : mag_t;
        if (n_scale > SCALE_MAX)      mag = '1;
        else if (n_scale < SCALE_MIN) mag = {{(NBITS-2){1'b0}}, 1'b1};

        if (n_inf)       enc_result = {1'b1, {(NBITS-1){1'b0}}};
        else if (n_zero) enc_result = '0;
        else             enc_result = n_sign ? -{1'b0, mag} : {1'b0, mag};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op1      <= '0;
            op2      <= '0;
            cnt      <= '0;
            quo      <= '0;
            rem      <= '0;
            n_frac   <= '0;
            n_scale  <= '0;
            n_sticky <= 1'b0;
            n_sign   <= 1'b0;
            n_inf    <= 1'b0;
            n_zero   <= 1'b0;
            result   <= '0;
            inf      <= 1'b0;
            zero     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op1 <= in1;
                        op2 <= in2;
                        cnt <= '0;
                    end
                end
                DIVIDE: begin
                    quo <= q_next;
                    rem <= rem_next;
                    cnt <= cnt + 1'b1;
                end
                ENCODE: begin
                    n_frac   <= norm_frac;
                    n_scale  <= norm_scale;
                    n_sticky <= |rem;
                    n_sign   <= dec1.sign ^ dec2.sign;
                    n_inf    <= dec1.inf | dec2.inf | dec2.zero;
                    n_zero   <= ~(dec1.inf | dec2.inf | dec2.zero) & dec1.zero;
                end
                DONE: begin
                    result <= enc_result;
                    inf    <= n_inf;
                    zero   <= n_zero;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_positdiv_seq.sv
// Directed bench for positdiv_seq: arithmetic vectors, special cases, start masking, mid-op reset.
module tb_positdiv_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] in1, in2;
    logic [31:0] result;
    logic        inf, zero, done, busy;

    int checks = 0;
    int errors = 0;

    positdiv_seq #(.NBITS(32), .ES(2), .QBITS(30)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .in1(in1), .in2(in2),
        .result(result), .inf(inf), .zero(zero), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic i_f, output logic z_f,
                          output int lat);
        @(negedge clk);
        in1 = a; in2 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result; i_f = inf; z_f = zero;
    endtask

    task automatic test_reset;
        reset_n = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
        #2 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected %h", result, 32'h0); end
        checks++; if (inf !== 1'b0)  begin errors++; $display("FAIL reset_inf: got %b expected 0", inf); end
        checks++; if (zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", zero); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_unity;
        logic [31:0] r; logic i_f, z_f; int lat; logic b_seen;
        @(negedge clk);
        in1 = 32'h40000000; in2 = 32'h40000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        b_seen = busy;
        lat = 0;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        r = result; i_f = inf; z_f = zero;
        checks++; if (b_seen !== 1'b1) begin errors++; $display("FAIL unity_busy: got %b expected 1", b_seen); end
        checks++; if (lat != 32) begin errors++; $display("FAIL unity_latency: got %0d expected 32", lat); end
        checks++; if (r !== 32'h40000000) begin errors++; $display("FAIL unity_result: got %h expected %h", r, 32'h40000000); end
        checks++; if (i_f !== 1'b0 || z_f !== 1'b0) begin errors++; $display("FAIL unity_flags: got inf=%b zero=%b expected 0 0", i_f, z_f); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL unity_busy_at_done: got %b expected 0", busy); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL unity_done_width: got %b expected 0", done); end
        in1 = 32'h12345678; in2 = 32'h0badcafe;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (result !== 32'h40000000) begin errors++; $display("FAIL unity_hold: got %h expected %h", result, 32'h40000000); end
    endtask

    task automatic test_arith;
        logic [31:0] r; logic i_f, z_f; int lat;
        run_op(32'h40000000, 32'h48000000, r, i_f, z_f, lat);
        checks++; if (r !== 32'h38000000) begin errors++; $display("FAIL div_half: got %h expected %h", r, 32'h38000000); end
        checks++; if (lat != 32) begin errors++; $display("FAIL div_half_latency: got %0d expected 32", lat); end
        run_op(32'h40000000, 32'h4C000000, r, i_f, z_f, lat);
        checks++; if (r !== 32'h32AAAAAB) begin errors++; $display("FAIL div_third: got %h expected %h", r, 32'h32AAAAAB); end
        run_op(32'hC0000000, 32'h48000000, r, i_f, z_f, lat);
        checks++; if (r !== 32'hC8000000) begin errors++; $display("FAIL div_neg_half: got %h expected %h", r, 32'hC8000000); end
        checks++; if (i_f !== 1'b0 || z_f !== 1'b0) begin errors++; $display("FAIL div_neg_flags: got inf=%b zero=%b expected 0 0", i_f, z_f); end
    endtask

    task automatic test_special;
        logic [31:0] va [6] = '{32'h40000000, 32'h00000000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h00000000};
        logic [31:0] vb [6] = '{32'h00000000, 32'h40000000, 32'h00000001, 32'h7FFFFFFF, 32'h40000000, 32'h00000000};
        logic [31:0] vr [6] = '{32'h80000000, 32'h00000000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h80000000};
        logic        vi [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic        vz [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [31:0] r; logic i_f, z_f; int lat;
        for (int n = 0; n < 6; n++) begin
            run_op(va[n], vb[n], r, i_f, z_f, lat);
            checks++; if (r !== vr[n]) begin errors++; $display("FAIL special%0d_result: got %h expected %h", n, r, vr[n]); end
            checks++; if (i_f !== vi[n] || z_f !== vz[n]) begin errors++; $display("FAIL special%0d_flags: got inf=%b zero=%b expected %b %b", n, i_f, z_f, vi[n], vz[n]); end
            checks++; if (lat != 32) begin errors++; $display("FAIL special%0d_latency: got %0d expected 32", n, lat); end
        end
    endtask

    task automatic test_back_to_back;
        int lat; int extra;
        @(negedge clk);
        in1 = 32'h40000000; in2 = 32'h4C000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            if (lat == 4) begin start = 1'b1; in1 = 32'h40000000; in2 = 32'h40000000; end
            else if (lat == 5) start = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        checks++; if (lat != 32) begin errors++; $display("FAIL ignore_latency: got %0d expected 32", lat); end
        checks++; if (result !== 32'h32AAAAAB) begin errors++; $display("FAIL ignore_result: got %h expected %h", result, 32'h32AAAAAB); end
        extra = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL ignore_no_queue: got %0d extra done pulses expected 0", extra); end
    endtask

    task automatic test_reset_mid;
        int lat;
        @(negedge clk);
        in1 = 32'h40000000; in2 = 32'h4C000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL midreset_result: got %h expected %h", result, 32'h0); end
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got done=%b busy=%b expected 0 0", done, busy); end
        checks++; if (inf !== 1'b0 || zero !== 1'b0) begin errors++; $display("FAIL midreset_flags: got inf=%b zero=%b expected 0 0", inf, zero); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        in1 = 32'h40000000; in2 = 32'h48000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin @(posedge clk); #1; lat++; end
        checks++; if (lat != 32) begin errors++; $display("FAIL postreset_latency: got %0d expected 32", lat); end
        checks++; if (result !== 32'h38000000) begin errors++; $display("FAIL postreset_result: got %h expected %h", result, 32'h38000000); end
    endtask

    initial begin
        test_reset;
        test_unity;
        test_arith;
        test_special;
        test_back_to_back;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
